serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port START  input  1  request to begin an addition; sampled on the CLK rising edge.
REQ-005 The block SHALL have port A  input  N  first operand; captured only when START is accepted.
REQ-006 The block SHALL have port B  input  N  second operand; captured only when START is accepted.
REQ-007 The block SHALL have port CIN  input  1  carry-in; captured only when START is accepted.
REQ-008 The block SHALL have port BUSY  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port DONE  output  1  one-cycle pulse marking a new valid result.
REQ-010 The block SHALL have port SUM  output  N  registered result of the last completed addition.
REQ-011 The block SHALL have port COUT  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL add A+B+CIN bit-serially, LSB first, one bit per clock, using a single 1-bit full-adder cell (sum = x^y^c, carry = majority(x,y,c)).
REQ-013 The block SHALL implement an FSM with states IDLE, RUN and FIN.
REQ-014 IDLE or FIN with START=1 at an edge SHALL capture A, B and CIN into internal shift/carry registers, clear the bit counter and enter RUN.
REQ-015 IDLE with START=0 SHALL stay in IDLE; FIN with START=0 SHALL go to IDLE after one cycle.
REQ-016 Each edge in RUN SHALL apply the full-adder cell to the operand LSBs and the carry register, shift the sum bit into the partial-sum MSB, shift both operands right by one, update the carry and increment the counter.
REQ-017 On the edge that processes bit N-1, the block SHALL load SUM from the completed partial sum and COUT from the final carry, and SHALL enter FIN.
REQ-018 START accepted at edge 0 SHALL give BUSY=1 after edges 0..N-1, and DONE=1, BUSY=0 with valid SUM/COUT after edge N; total latency SHALL be N+1 edges.
REQ-019 DONE SHALL be high only in FIN, and BUSY SHALL be high only in RUN.
REQ-020 START while in RUN SHALL be ignored; the operation in progress and its operands SHALL be unaffected.
REQ-021 SUM and COUT SHALL hold their value between completions and SHALL NOT show partial results.
REQ-022 START in FIN SHALL be accepted (back-to-back operation); DONE SHALL fall and BUSY SHALL rise on that edge.
REQ-023 Overflow of the N-bit sum SHALL wrap modulo 2^N, with the carry reported only on COUT.

Reset
REQ-024 RESET=1 SHALL immediately, without a clock, force state IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, and clear the counter, carry and shift registers.
REQ-025 RESET asserted mid-RUN SHALL abandon the operation and produce no DONE pulse; the first START after release SHALL behave as from power-up.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port V (1 bit), the signed two's-complement overflow, equal to the carry into bit N-1 XOR the carry out of bit N-1; V SHALL be registered with SUM, cleared by reset and held between completions.
REQ-027 Without SERIAL_ADDER_OVF_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=8)
REQ-028 A=8'h00, B=8'h00, CIN=0, START pulse at edge 0 -> DONE=1 only after edge 8, SUM=8'h00, COUT=0, BUSY high after edges 0..7.
REQ-029 A=8'hFF, B=8'h01, CIN=0 -> SUM=8'h00, COUT=1; then A=8'hFF, B=8'hFF, CIN=1 -> SUM=8'hFF, COUT=1.
REQ-030 A=8'h12, B=8'h34, then START re-pulsed at edge 3 with A=8'hAA, B=8'h55 -> the re-pulse is ignored; SUM=8'h46, COUT=0 after edge 8.
REQ-031 START held high continuously with A=8'h01, B=8'h02 -> results every 9 edges, SUM=8'h03, DONE one cycle wide each time.
REQ-032 RESET asserted between edges 4 and 5 of an operation -> BUSY, DONE, SUM and COUT go to 0 immediately, with no DONE pulse; a following 8'h10+8'h20 gives SUM=8'h30.
REQ-033 With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> SUM=8'h80, V=1, COUT=0; 8'h80+8'hFF -> SUM=8'h7F, V=1, COUT=1; 8'h05+8'h03 -> V=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial adder with handshake control. A START accepted in IDLE or FIN
// captures A, B and CIN. One operand bit per clock, LSB first, is then pushed
// through a single 1-bit full-adder cell. The N-bit result and carry-out are
// published together on the edge that processes the MSB. That edge enters FIN,
// where DONE is high for exactly one cycle.
//
// Timing: START accepted at edge 0 gives BUSY=1 after edges 0..N-1. After
// edge N, DONE=1, BUSY=0 and SUM/COUT are valid, so the latency is N+1 edges.
// START is honoured again in FIN, which allows back-to-back additions.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add output V. V is the
// signed two's-complement overflow, registered alongside SUM.
//
// Parameters
//   N      operand width in bits (2..32)
//
// Ports
//   CLK    in   1  system clock, rising edge active
//   RESET  in   1  asynchronous active-high reset
//   START  in   1  request a new addition
//   A      in   N  first operand (captured on accepted START)
//   B      in   N  second operand (captured on accepted START)
//   CIN    in   1  carry-in (captured on accepted START)
//   BUSY   out  1  high while the addition is in progress (RUN)
//   DONE   out  1  one-cycle pulse marking a new result (FIN)
//   SUM    out  N  result of the last completed addition
//   COUT   out  1  carry-out of the last completed addition
//   V      out  1  signed overflow of the last addition (SERIAL_ADDER_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] SUM,
    output logic         COUT
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         V
`endif
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_ps;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_sum_bit;
    logic               w_carry;
    logic               w_last;
    logic [N-1:0]       w_ps_next;

    // Single 1-bit full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    assign w_sum_bit = fa_sum(r_a[0], r_b[0], r_c);
    assign w_carry   = fa_carry(r_a[0], r_b[0], r_c);
    assign w_last    = (r_cnt == CNT_W'(N - 1));
    // Partial sum fills from the MSB end. After N shifts, bit 0 of the result
    // sits at bit 0.
    assign w_ps_next = {w_sum_bit, r_ps[N-1:1]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_ps    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SUM     <= '0;
            COUT    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            V       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, FIN: begin
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_c     <= CIN;
                        r_ps    <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        BUSY    <= 1'b1;
                        DONE    <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b0;
                    end
                end

                RUN: begin
                    // START is deliberately not examined here. A re-request
                    // during an addition has no effect on the addition.
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_ps  <= w_ps_next;
                    r_c   <= w_carry;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Publish only on completion, so SUM/COUT never show
                        // partial results.
                        SUM     <= w_ps_next;
                        COUT    <= w_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // r_c is the carry into bit N-1 at this step.
                        V       <= r_c ^ w_carry;
`endif
                        r_state <= FIN;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         CIN;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] SUM;
    logic         COUT;
`ifdef SERIAL_ADDER_OVF_EN
    logic         V;
`endif

    serial_adder_ctrl #(.N(N)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         v;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] last_sum;
    logic         last_cout;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin);
        exp_t     e;
        logic [N:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        e.sum  = t[N-1:0];
        e.cout = t[N];
        e.v    = (a[N-1] == b[N-1]) && (t[N-1] != a[N-1]);
        return e;
    endfunction

    // Advance one clock edge and settle, so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        START = 1'b0;
        A = '0; B = '0; CIN = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, SUM, COUT} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     BUSY, DONE, SUM, COUT);
        end
`ifdef SERIAL_ADDER_OVF_EN
        checks++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL reset_v got %b want 0", V);
        end
`endif
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", BUSY, DONE);
        end
        last_sum  = '0;
        last_cout = 1'b0;
    endtask

    // One complete addition with exact latency checks and a scoreboard compare at DONE.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input string name);
        exp_t e;
        A = a; B = b; CIN = cin; START = 1'b1;
        tick();                                   // edge 0
        START = 1'b0;
        A = N'($urandom); B = N'($urandom); CIN = 1'($urandom);
        sb.push_back(model(a, b, cin));
        for (int i = 0; i < N; i++) begin
            if (i > 0) tick();                    // edges 1..N-1
            checks++;
            if (BUSY !== 1'b1 || DONE !== 1'b0 || SUM !== last_sum || COUT !== last_cout) begin
                errors++;
                $display("FAIL %s_run_edge%0d got busy=%b done=%b sum=%h cout=%b want 1 0 %h %b",
                         name, i, BUSY, DONE, SUM, COUT, last_sum, last_cout);
            end
        end
        tick();                                   // edge N
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b want 1 0", name, DONE, BUSY);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard got empty want entry", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (SUM !== e.sum || COUT !== e.cout) begin
                errors++;
                $display("FAIL %s_result got sum=%h cout=%b want sum=%h cout=%b",
                         name, SUM, COUT, e.sum, e.cout);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (V !== e.v) begin
                errors++;
                $display("FAIL %s_v got %b want %b", name, V, e.v);
            end
`endif
            last_sum  = e.sum;
            last_cout = e.cout;
        end
        tick();                                   // back to IDLE
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || SUM !== last_sum) begin
            errors++;
            $display("FAIL %s_idle_hold got done=%b busy=%b sum=%h want 0 0 %h",
                     name, DONE, BUSY, SUM, last_sum);
        end
    endtask

    task automatic test_basic();
        run_op(8'h00, 8'h00, 1'b0, "zero");
        run_op(8'hFF, 8'h01, 1'b0, "wrap");
        run_op(8'hFF, 8'hFF, 1'b1, "allones_cin");
    endtask

    task automatic test_start_ignored();
        exp_t e;
        A = 8'h12; B = 8'h34; CIN = 1'b0; START = 1'b1;
        tick();                                   // edge 0
        START = 1'b0;
        sb.push_back(model(8'h12, 8'h34, 1'b0));
        tick();                                   // edge 1
        tick();                                   // edge 2
        A = 8'hAA; B = 8'h55; START = 1'b1;
        tick();                                   // edge 3, ignored
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy got busy=%b done=%b want 1 0", BUSY, DONE);
        end
        for (int i = 4; i < N; i++) tick();       // edges 4..7
        tick();                                   // edge 8
        checks++;
        if (DONE !== 1'b1) begin
            errors++;
            $display("FAIL restart_done got %b want 1", DONE);
        end
        e = sb.pop_front();
        checks++;
        if (SUM !== e.sum || COUT !== e.cout) begin
            errors++;
            $display("FAIL restart_result got sum=%h cout=%b want sum=%h cout=%b",
                     SUM, COUT, e.sum, e.cout);
        end
        last_sum  = e.sum;
        last_cout = e.cout;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        A = 8'h01; B = 8'h02; CIN = 1'b0; START = 1'b1;
        tick();                                   // edge 0 accepted
        sb.push_back(model(8'h01, 8'h02, 1'b0));
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i < N; i++) tick();
            tick();                               // completion edge
            checks++;
            if (DONE !== 1'b1 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done%0d got done=%b busy=%b want 1 0", k, DONE, BUSY);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_scoreboard%0d got empty want entry", k);
            end else begin
                e = sb.pop_front();
                checks++;
                if (SUM !== e.sum || COUT !== e.cout) begin
                    errors++;
                    $display("FAIL b2b_result%0d got sum=%h cout=%b want sum=%h cout=%b",
                             k, SUM, COUT, e.sum, e.cout);
                end
                last_sum  = e.sum;
                last_cout = e.cout;
            end
            if (k == 0) begin
                tick();                           // re-accepted in FIN
                sb.push_back(model(8'h01, 8'h02, 1'b0));
                checks++;
                if (DONE !== 1'b0 || BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_restart got done=%b busy=%b want 0 1", DONE, BUSY);
                end
            end
        end
        START = 1'b0;
        tick();
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got done=%b busy=%b want 0 0", DONE, BUSY);
        end
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        A = 8'h55; B = 8'h0F; CIN = 1'b1; START = 1'b1;
        tick();                                   // edge 0
        START = 1'b0;
        for (int i = 1; i <= 4; i++) tick();      // edges 1..4
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({BUSY, DONE, SUM, COUT} !== {1'b0, 1'b0, {N{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0",
                     BUSY, DONE, SUM, COUT);
        end
        last_sum  = '0;
        last_cout = 1'b0;
        tick();
        RESET = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE !== 1'b0 || BUSY !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrun_no_done got activity=1 want 0");
        end
        run_op(8'h10, 8'h20, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_op(N'($urandom_range(0, 255)), N'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), "random");
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_overflow();
        run_op(8'h7F, 8'h01, 1'b0, "ovf_pos");
        run_op(8'h80, 8'hFF, 1'b0, "ovf_neg");
        run_op(8'h05, 8'h03, 1'b0, "ovf_none");
    endtask
`endif

    initial begin
        fork
            begin
                test_reset();
                test_basic();
                test_start_ignored();
                test_back_to_back();
                test_reset_midrun();
                test_random();
`ifdef SERIAL_ADDER_OVF_EN
                test_overflow();
`endif
            end
            begin
                #200000;
                errors++;
                $display("FAIL timeout got running want finished");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "timeout");
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
